// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the multi-beat RAM controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Number of RAM beats per client word; DATA_W/RAM_W must be a power of two.
    function automatic int beats_of(input int data_w, input int ram_w);
        return data_w / ram_w;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fetch/memory-stage arbiter: memory stage has priority over fetch.
// With MEM_CTRL_STARVE_GUARD_EN defined, fetch is forced through after STARVE_LIMIT back-to-back mem grants.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic mem_req,
    output logic gnt_valid,
    output logic gnt_src
);

`ifdef MEM_CTRL_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        gnt_valid = arb_en && (if_req || mem_req);
        gnt_src   = (mem_req && !starved) ? GNT_MEM : GNT_IF;
    end

    // Only counts mem grants that actually made fetch wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (gnt_valid) begin
            if (gnt_src == GNT_IF)
                starve_cnt <= '0;
            else if (if_req)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    always_comb begin
        gnt_valid = arb_en && (if_req || mem_req);
        gnt_src   = mem_req ? GNT_MEM : GNT_IF;
    end
`endif

endmodule

// File: rtl/mem_ctrl_multibeat.sv
// Multi-beat RAM controller: splits DATA_W client words into BEATS RAM_W beats, MS beat first.
// Optional MEM_CTRL_STARVE_GUARD_EN enables the fetch starvation guard inside mem_ctrl_arb.
module mem_ctrl_multibeat
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int RAM_W        = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wre,
    output logic [RAM_W-1:0]  ram_wdata,
    input  logic [RAM_W-1:0]  ram_rdata
);

    localparam int BEATS = beats_of(DATA_W, RAM_W);
    localparam int CNT_W = $clog2(BEATS + 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  beat_cnt;
    logic              src_q;
    logic              we_q;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] wr_buf;

    logic              arb_en;
    logic              gnt_valid;
    logic              gnt_src;
    logic              gnt_we;
    logic [ADDR_W-1:0] base_addr;

    // The cycle after ACK still sees the old request held high; skip
    // arbitration while an ack is out so it is not served twice.
    assign arb_en    = (state == IDLE) && !if_ack && !mem_ack;
    assign gnt_we    = (gnt_src == GNT_MEM) && mem_we;
    assign base_addr = ((gnt_src == GNT_MEM) ? mem_addr : if_addr) & ~ADDR_W'(BEATS - 1);

    mem_ctrl_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .arb_en    (arb_en),
        .if_req    (if_req),
        .mem_req   (mem_req),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (gnt_valid) state_d = gnt_we ? WRITE : READ;
            READ:    if (beat_cnt == CNT_W'(BEATS)) state_d = ACK;
            WRITE:   if (beat_cnt == CNT_W'(BEATS - 1)) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            src_q     <= GNT_IF;
            we_q      <= 1'b0;
            rd_buf    <= '0;
            wr_buf    <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wre   <= 1'b1;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            ram_wre <= (state_d != WRITE);
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        src_q    <= gnt_src;
                        we_q     <= gnt_we;
                        beat_cnt <= '0;
                        ram_addr <= base_addr;
                        if (gnt_we) begin
                            ram_wdata <= mem_wdata[DATA_W-1 -: RAM_W];
                            wr_buf    <= mem_wdata << RAM_W;
                        end
                    end
                end
                READ: begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt < CNT_W'(BEATS - 1))
                        ram_addr <= ram_addr + 1'b1;
                    // Beat n's data returns while beat_cnt == n+1.
                    if (beat_cnt != '0)
                        rd_buf <= (rd_buf << RAM_W) | DATA_W'(ram_rdata);
                end
                WRITE: begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt < CNT_W'(BEATS - 1)) begin
                        ram_addr  <= ram_addr + 1'b1;
                        ram_wdata <= wr_buf[DATA_W-1 -: RAM_W];
                        wr_buf    <= wr_buf << RAM_W;
                    end
                end
                ACK: begin
                    if (src_q == GNT_MEM) begin
                        mem_ack <= 1'b1;
                        if (!we_q) mem_rdata <= rd_buf;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= rd_buf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_multibeat.sv
// Directed bench for mem_ctrl_multibeat with a synchronous-read RAM model.
// Honors MEM_CTRL_STARVE_GUARD_EN for the expected arbitration order.
module tb_mem_ctrl_multibeat;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int RAM_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wre;
    logic [RAM_W-1:0]  ram_wdata;
    logic [RAM_W-1:0]  ram_rdata;

    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [RAM_W-1:0]  bd_data = '0;
    logic [RAM_W-1:0]  ram [0:(1<<ADDR_W)-1];

    int vectors = 0;
    int miscompares = 0;

    mem_ctrl_multibeat #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_W(RAM_W), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bd_we)        ram[bd_addr] <= bd_data;
        else if (!ram_wre) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [RAM_W-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".if_ack"},    64'(if_ack),    64'd0);
        check({tag, ".mem_ack"},   64'(mem_ack),   64'd0);
        check({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
        check({tag, ".mem_rdata"}, 64'(mem_rdata), 64'd0);
        check({tag, ".ram_addr"},  64'(ram_addr),  64'd0);
        check({tag, ".ram_wdata"}, 64'(ram_wdata), 64'd0);
        check({tag, ".ram_wre"},   64'(ram_wre),   64'd1);
    endtask

    initial begin
        int mcnt, icnt, mfirst, ifirst, n, acks_after;
        logic seq [6];
        logic exp_seq [6];

        // Preload RAM while in reset.
        poke(18'h00100, 16'hABCD);
        poke(18'h00101, 16'h1234);
        poke(18'h3FFFE, 16'h1111);
        poke(18'h3FFFF, 16'h2222);
        poke(18'h00300, 16'h0000);
        poke(18'h00301, 16'h0000);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Two-beat read of 0x100.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00100;
        tick();
        check("rd.addr0", 64'(ram_addr), 64'h100);
        check("rd.wre0",  64'(ram_wre),  64'd1);
        tick();
        check("rd.addr1", 64'(ram_addr), 64'h101);
        tick(2);
        check("rd.noack3", 64'(mem_ack), 64'd0);
        tick();
        check("rd.ack4",   64'(mem_ack),   64'd1);
        check("rd.data",   64'(mem_rdata), 64'hABCD1234);
        check("rd.noifack", 64'(if_ack),   64'd0);
        mem_req = 1'b0;
        tick();
        check("rd.ackpulse", 64'(mem_ack), 64'd0);
        tick();

        // Two-beat write to 0x203 (base 0x202).
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00203; mem_wdata = 32'hDEADBEEF;
        tick();
        check("wr.addr0",  64'(ram_addr),  64'h202);
        check("wr.data0",  64'(ram_wdata), 64'hDEAD);
        check("wr.wre0",   64'(ram_wre),   64'd0);
        tick();
        check("wr.addr1",  64'(ram_addr),  64'h203);
        check("wr.data1",  64'(ram_wdata), 64'hBEEF);
        check("wr.wre1",   64'(ram_wre),   64'd0);
        tick();
        check("wr.wre2",   64'(ram_wre),   64'd1);
        check("wr.noack2", 64'(mem_ack),   64'd0);
        tick();
        check("wr.ack3",   64'(mem_ack),   64'd1);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        check("wr.ram202", 64'(ram[18'h202]), 64'hDEAD);
        check("wr.ram203", 64'(ram[18'h203]), 64'hBEEF);

        // Simultaneous requests: mem first, then fetch.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00100;
        if_req = 1'b1; if_addr = 18'h00202;
        mcnt = 0; icnt = 0; mfirst = 0; ifirst = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (mem_ack) begin mcnt++; if (mfirst == 0) mfirst = cyc; mem_req = 1'b0; end
            if (if_ack)  begin icnt++; if (ifirst == 0) ifirst = cyc; if_req = 1'b0; end
        end
        check("both.mem_cnt",   64'(mcnt),   64'd1);
        check("both.if_cnt",    64'(icnt),   64'd1);
        check("both.mem_cycle", 64'(mfirst), 64'd5);
        check("both.if_cycle",  64'(ifirst), 64'd11);
        check("both.if_rdata",  64'(if_rdata),  64'hDEADBEEF);
        check("both.mem_rdata", 64'(mem_rdata), 64'hABCD1234);

        // Mem held continuously with fetch waiting.
`ifdef MEM_CTRL_STARVE_GUARD_EN
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        seq = '{default: 1'b0};
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00100;
        if_req = 1'b1; if_addr = 18'h00202;
        n = 0;
        for (int cyc = 0; cyc < 80 && n < 6; cyc++) begin
            tick();
            if (mem_ack) begin seq[n] = 1'b1; n++; end
            else if (if_ack) begin seq[n] = 1'b0; n++; if_req = 1'b0; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        check("starve.count", 64'(n), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("starve.grant%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
        tick(10);

        // Top-of-address-space reads.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h3FFFE;
        tick();
        check("top.addr0", 64'(ram_addr), 64'h3FFFE);
        tick();
        check("top.addr1", 64'(ram_addr), 64'h3FFFF);
        tick(3);
        check("top.ack",  64'(mem_ack),   64'd1);
        check("top.data", 64'(mem_rdata), 64'h11112222);
        mem_req = 1'b0;
        tick(2);
        poke(18'h3FFFE, 16'h5555);
        mem_req = 1'b1; mem_addr = 18'h3FFFF;
        tick();
        check("align.addr0", 64'(ram_addr), 64'h3FFFE);
        tick();
        check("align.addr1", 64'(ram_addr), 64'h3FFFF);
        tick(3);
        check("align.ack",  64'(mem_ack),   64'd1);
        check("align.data", 64'(mem_rdata), 64'h55552222);
        mem_req = 1'b0;
        tick(2);

        // Reset during the first write beat aborts the transfer.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00301; mem_wdata = 32'h11112222;
        tick();
        check("abort.wre0", 64'(ram_wre), 64'd0);
        #1 reset = 1'b1;
        #1 check_reset_outputs("abort");
        mem_req = 1'b0; mem_we = 1'b0;
        tick(2);
        reset = 1'b0;
        acks_after = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (mem_ack || if_ack) acks_after++;
        end
        check("abort.no_ack",  64'(acks_after),   64'd0);
        check("abort.ram301",  64'(ram[18'h301]), 64'd0);
        check("abort.wre_idle", 64'(ram_wre),     64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
